// File: rtl/fir_sample_sequencer_if.sv
// fir_sample_sequencer_if: sample-source and FIR-core signals of one sequencer
// master drives wrt_smpl/smpl_in and observes the rest; slave is the sequencer side
interface fir_sample_sequencer_if;
  logic               wrt_smpl;
  logic signed [15:0] smpl_in;
  logic               sequencing;
  logic signed [15:0] smpl_out;
  logic               full;
  logic               overrun;
  modport master (output wrt_smpl, smpl_in, input sequencing, smpl_out, full, overrun);
  modport slave  (input wrt_smpl, smpl_in, output sequencing, smpl_out, full, overrun);
endinterface

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: circular sample buffer that streams the newest NUM_TAPS samples oldest-first to a FIR core
// clk, rst_n (async, active-low); bus.slave: wrt_smpl/smpl_in in, sequencing/smpl_out/full/overrun out (all registered)
module fir_sample_sequencer #(
  parameter int DEPTH    = 1024,
  parameter int NUM_TAPS = 1021,
  parameter int FLUSH    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  fir_sample_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_TAPS + 1);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SEQ, S_FLUSH} state_t;
  logic signed [15:0] mem [DEPTH];
  logic signed [15:0] rd_data, smpl_out_q, smpl_out_d;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, base, rd_addr;
  logic [CW-1:0] fill_q, fill_d, cnt_q, cnt_d;
  logic pending_q, pending_d, sequencing_q, sequencing_d, full_q, full_d, overrun_q, overrun_d;
  logic consume, accept, last_tap, last_flush, pre_flush;
  always_comb begin
    last_tap     = cnt_q == CW'(NUM_TAPS - 1);
    last_flush   = cnt_q == CW'(FLUSH - 1);
    pre_flush    = int'(cnt_q) == FLUSH - 2;
    // a pending burst is started from IDLE, or at the edge entering the last
    // flush cycle so that cycle doubles as PRIME and sequencing never drops
    consume      = pending_q && (state_q == S_IDLE ||
                   (state_q == S_SEQ && last_tap && FLUSH == 1) ||
                   (state_q == S_FLUSH && (last_flush || pre_flush)));
    // a strobe on the consuming edge belongs to the next burst and is kept
    accept       = bus.wrt_smpl && (!pending_q || consume);
    overrun_d    = bus.wrt_smpl && !accept;
    base         = wr_ptr_q - AW'(NUM_TAPS);
    rd_addr      = consume ? base : rd_ptr_q;
    rd_ptr_d     = rd_addr + 1'b1;
    wr_ptr_d     = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d       = (accept && fill_q != CW'(NUM_TAPS)) ? fill_q + 1'b1 : fill_q;
    full_d       = fill_d == CW'(NUM_TAPS);
    pending_d    = (pending_q && !consume) || (accept && full_d);
    state_d      = state_q;
    cnt_d        = cnt_q;
    sequencing_d = 1'b1;
    smpl_out_d   = '0;
    case (state_q)
      S_IDLE: begin
        sequencing_d = 1'b0;
        state_d      = consume ? S_PRIME : S_IDLE;
      end
      S_PRIME: begin
        state_d    = S_SEQ;
        cnt_d      = '0;
        smpl_out_d = rd_data;
      end
      S_SEQ: begin
        state_d    = !last_tap ? S_SEQ : consume ? S_PRIME : S_FLUSH;
        cnt_d      = last_tap ? '0 : cnt_q + 1'b1;
        smpl_out_d = last_tap ? '0 : rd_data;
      end
      default: begin
        state_d      = consume ? S_PRIME : last_flush ? S_IDLE : S_FLUSH;
        cnt_d        = cnt_q + 1'b1;
        sequencing_d = !last_flush;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.smpl_in;
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      sequencing_q <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      smpl_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      sequencing_q <= sequencing_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      smpl_out_q   <= smpl_out_d;
    end
  end
  assign bus.sequencing = sequencing_q;
  assign bus.smpl_out   = smpl_out_q;
  assign bus.full       = full_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer: directed vectors for a small (8/5/2) and a default-size sequencer
module tb_fir_sample_sequencer;
  logic clk = 1'b0;
  logic rst_s, rst_l;
  int checks = 0, failures = 0, rises = 0;
  logic prev_seq = 1'b0;
  logic [15:0] got[$];
  fir_sample_sequencer_if s_if();
  fir_sample_sequencer_if l_if();
  fir_sample_sequencer #(.DEPTH(8), .NUM_TAPS(5), .FLUSH(2)) u_s (.clk(clk), .rst_n(rst_s), .bus(s_if));
  fir_sample_sequencer u_l (.clk(clk), .rst_n(rst_l), .bus(l_if));
  always #5 clk = ~clk;
  typedef struct {
    logic        w;
    logic [15:0] d;
    logic        seq;
    logic [15:0] out;
    logic        full;
  } vec_t;
  vec_t tbl[15];
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic [15:0] d);
    s_if.wrt_smpl = w;
    s_if.smpl_in  = d;
    @(negedge clk);
    if (s_if.sequencing) begin
      got.push_back(s_if.smpl_out);
      if (!prev_seq) rises++;
    end
    prev_seq = s_if.sequencing;
  endtask
  task automatic reset_s();
    s_if.wrt_smpl = 1'b0;
    s_if.smpl_in  = '0;
    rst_s = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    got.delete();
    rises = 0;
    prev_seq = 1'b0;
  endtask
  task automatic check_q(input string nm, input logic [15:0] exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask
  function automatic logic [15:0] ramp(input int i);
    return (i == 1020) ? 16'h7fff : 16'(i * 64 - 32768);
  endfunction
  initial begin
    logic [15:0] e[$];
    logic [15:0] lq[$];
    int hi, lat;
    logic lprev;
    tbl[0]  = '{1'b1, 16'd1, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'd3, 1'b0, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 16'd4, 1'b0, 16'd0, 1'b0};
    tbl[4]  = '{1'b1, 16'd5, 1'b0, 16'd0, 1'b1};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 16'd1, 1'b1};
    tbl[7]  = '{1'b0, 16'd0, 1'b1, 16'd2, 1'b1};
    tbl[8]  = '{1'b0, 16'd0, 1'b1, 16'd3, 1'b1};
    tbl[9]  = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 16'd5, 1'b1};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 16'd0, 1'b1};
    tbl[12] = '{1'b0, 16'd0, 1'b1, 16'd0, 1'b1};
    tbl[13] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1};
    tbl[14] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1};
    s_if.wrt_smpl = 1'b0;
    s_if.smpl_in  = '0;
    l_if.wrt_smpl = 1'b0;
    l_if.smpl_in  = '0;
    rst_s = 1'b0;
    rst_l = 1'b0;
    @(negedge clk);
    check("rst_seq", s_if.sequencing, 0);
    check("rst_out", s_if.smpl_out, 0);
    check("rst_full", s_if.full, 0);
    check("rst_ovr", s_if.overrun, 0);
    rst_s = 1'b1;
    rst_l = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_if.wrt_smpl = tbl[i].w;
      s_if.smpl_in  = tbl[i].d;
      @(negedge clk);
      check($sformatf("fill_seq[%0d]", i), s_if.sequencing, tbl[i].seq);
      check($sformatf("fill_out[%0d]", i), s_if.smpl_out, tbl[i].out);
      check($sformatf("fill_full[%0d]", i), s_if.full, tbl[i].full);
      check($sformatf("fill_ovr[%0d]", i), s_if.overrun, 0);
    end
    for (int v = 6; v <= 12; v++) begin
      got.delete();
      cyc(1'b1, 16'(v));
      repeat (19) cyc(1'b0, '0);
      e = {};
      for (int j = 4; j >= 0; j--) e.push_back(16'(v - j));
      e.push_back(16'd0);
      e.push_back(16'd0);
      check_q($sformatf("wrap%0d", v), e);
    end
    check("wrap_rises", rises, 7);
    reset_s();
    for (int v = 1; v <= 5; v++) cyc(1'b1, 16'(v));
    repeat (2) cyc(1'b0, '0);
    cyc(1'b1, 16'd6);
    repeat (20) cyc(1'b0, '0);
    e = '{1, 2, 3, 4, 5, 0, 0, 2, 3, 4, 5, 6, 0, 0};
    check_q("b2b", e);
    check("b2b_rises", rises, 1);
    reset_s();
    for (int v = 1; v <= 5; v++) cyc(1'b1, 16'(v));
    cyc(1'b1, 16'd6);
    check("idle_wr_ovr", s_if.overrun, 0);
    repeat (20) cyc(1'b0, '0);
    check_q("idle_wr", e);
    check("idle_wr_rises", rises, 1);
    reset_s();
    for (int v = 1; v <= 5; v++) cyc(1'b1, 16'(v));
    repeat (2) cyc(1'b0, '0);
    cyc(1'b1, 16'd6);
    check("ovr_first", s_if.overrun, 0);
    cyc(1'b1, 16'd7);
    check("ovr_pulse", s_if.overrun, 1);
    cyc(1'b0, '0);
    check("ovr_clear", s_if.overrun, 0);
    repeat (12) cyc(1'b0, '0);
    cyc(1'b1, 16'd8);
    repeat (14) cyc(1'b0, '0);
    e = '{1, 2, 3, 4, 5, 0, 0, 2, 3, 4, 5, 6, 0, 0, 3, 4, 5, 6, 8, 0, 0};
    check_q("ovr", e);
    check("ovr_rises", rises, 2);
    reset_s();
    for (int v = 1; v <= 5; v++) cyc(1'b1, 16'(v));
    repeat (4) cyc(1'b0, '0);
    check("mid_pre_seq", s_if.sequencing, 1);
    check("mid_pre_out", s_if.smpl_out, 3);
    rst_s = 1'b0;
    #1;
    check("mid_rst_seq", s_if.sequencing, 0);
    check("mid_rst_out", s_if.smpl_out, 0);
    check("mid_rst_full", s_if.full, 0);
    @(negedge clk);
    rst_s = 1'b1;
    got.delete();
    rises = 0;
    prev_seq = 1'b0;
    for (int v = 11; v <= 14; v++) cyc(1'b1, 16'(v));
    repeat (8) cyc(1'b0, '0);
    check("mid_noburst", got.size(), 0);
    check("mid_notfull", s_if.full, 0);
    cyc(1'b1, 16'd15);
    repeat (12) cyc(1'b0, '0);
    e = '{11, 12, 13, 14, 15, 0, 0};
    check_q("mid", e);
    for (int i = 0; i < 1021; i++) begin
      l_if.wrt_smpl = 1'b1;
      l_if.smpl_in  = ramp(i);
      @(negedge clk);
    end
    l_if.wrt_smpl = 1'b0;
    check("big_full", l_if.full, 1);
    check("big_seq_idle", l_if.sequencing, 0);
    hi = 0;
    lat = -1;
    lprev = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (l_if.sequencing) begin
        if (lat < 0) lat = c;
        hi++;
        lq.push_back(l_if.smpl_out);
      end else if (lprev) break;
      lprev = l_if.sequencing;
    end
    check("big_latency", lat, 1);
    check("big_len", hi, 1023);
    for (int i = 0; i < 1023 && i < lq.size(); i++)
      check($sformatf("big[%0d]", i), lq[i], (i < 1021) ? ramp(i) : 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
